// File: rtl/io_pkg.sv
// Memory map shared by the memory-mapped I/O peripherals, plus read-address decode.
package io_pkg;

  localparam logic [31:0] OUTPUT_HEX_ADDR = 32'h0000_00B0;
  localparam logic [31:0] OUTPUT_LED_ADDR = 32'h0000_00B4;
  localparam logic [31:0] OUTPUT_CTL_ADDR = 32'h0000_00B8;

  localparam logic [31:0] INPUT_SW_ADDR   = 32'h0000_00C0;
  localparam logic [31:0] INPUT_KEY_ADDR  = 32'h0000_00C4;
  localparam logic [31:0] INPUT_EVT_ADDR  = 32'h0000_00C8;

  typedef enum logic [1:0] {
    SEL_SW,
    SEL_KEY,
    SEL_EVT,
    SEL_NONE
  } rd_sel_e;

  function automatic rd_sel_e decode_rd(input logic [31:0] addr);
    case (addr)
      INPUT_SW_ADDR:  return SEL_SW;
      INPUT_KEY_ADDR: return SEL_KEY;
      INPUT_EVT_ADDR: return SEL_EVT;
      default:        return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser and per-bit stability counter; chg pulses on the edge stable flips.
module debounce #(
  parameter int WIDTH  = 4,
  parameter int CYCLES = 500000
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] chg
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [WIDTH-1:0]         s1_q, s2_q;
  logic [WIDTH-1:0]         stable_q, stable_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    chg      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(CYCLES - 1)) begin
        stable_d[i] = s2_q[i];
        cnt_d[i]    = '0;
        chg[i]      = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= din;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/input_control.sv
// Memory-mapped switch/key input block: debounced levels, sticky key-press events, registered reads.
module input_control
  import io_pkg::*;
#(
  parameter int NUM_SW          = 10,
  parameter int NUM_KEY         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [31:0]        addr,
  input  logic               input_read,
  input  logic [NUM_SW-1:0]  sw,
  input  logic [NUM_KEY-1:0] key,
  output logic [31:0]        data_out,
  output logic               key_irq
);

  logic [NUM_KEY-1:0] key_in, key_stable, key_chg, key_rise;
  logic [NUM_SW-1:0]  sw_stable, sw_chg_unused;
  logic [NUM_KEY-1:0] evt_q, evt_d;
  logic [31:0]        data_q, data_d;
  logic               irq_q, irq_d;
  rd_sel_e            sel;

  // Internally a key bit is 1 when pressed, whatever the pin polarity.
  assign key_in = (KEY_ACTIVE_LOW != 0) ? ~key : key;

  debounce #(.WIDTH(NUM_SW), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clock  (clock),
    .resetn (resetn),
    .din    (sw),
    .stable (sw_stable),
    .chg    (sw_chg_unused)
  );

  debounce #(.WIDTH(NUM_KEY), .CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clock  (clock),
    .resetn (resetn),
    .din    (key_in),
    .stable (key_stable),
    .chg    (key_chg)
  );

  // A flip while the stable level is still 0 is a press landing on this edge.
  assign key_rise = key_chg & ~key_stable;
  assign sel      = decode_rd(addr);

  always_comb begin
    data_d = data_q;
    evt_d  = evt_q | key_rise;
    if (input_read) begin
      case (sel)
        SEL_SW:  data_d = 32'(sw_stable);
        SEL_KEY: data_d = 32'(key_stable);
        SEL_EVT: begin
          data_d = 32'(evt_q);
          evt_d  = key_rise;
        end
        default: data_d = 32'h0;
      endcase
    end
    irq_d = |evt_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
      evt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      evt_q  <= evt_d;
      irq_q  <= irq_d;
    end
  end

  assign data_out = data_q;
  assign key_irq  = irq_q;

endmodule

// File: tb/tb_input_control.sv
// Directed bench for input_control with a 4-cycle debounce window.
module tb_input_control;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic        input_read;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [31:0] data_out;
  logic        key_irq;

  int n_cmp = 0;
  int n_err = 0;

  input_control #(
    .NUM_SW(10), .NUM_KEY(4), .DEBOUNCE_CYCLES(4), .KEY_ACTIVE_LOW(1)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .addr       (addr),
    .input_read (input_read),
    .sw         (sw),
    .key        (key),
    .data_out   (data_out),
    .key_irq    (key_irq)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One read strobe sampled on the next edge; data_out is checked just after it.
  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    addr       = a;
    input_read = 1'b1;
    tick();
    input_read = 1'b0;
    chk(tag, data_out, exp);
  endtask

  initial begin
    resetn     = 1'b0;
    addr       = 32'h0;
    input_read = 1'b0;
    sw         = 10'h3FF;
    key        = 4'h0;

    // 1. reset values, then keys all pressed become visible after 2 + 4 edges
    ticks(3);
    chk("rst_data", data_out, 32'h0);
    chk("rst_irq", {31'b0, key_irq}, 32'h0);
    resetn = 1'b1;
    for (int k = 0; k <= 6; k++)
      rd(32'hC4, $sformatf("t1_key_e%0d", k), (k >= 6) ? 32'hF : 32'h0);
    chk("t1_irq", {31'b0, key_irq}, 32'h1);
    rd(32'hC8, "t1_evt", 32'hF);
    chk("t1_irq_clr", {31'b0, key_irq}, 32'h0);
    rd(32'hC0, "t1_sw", 32'h3FF);

    // 2. sw 0 -> 2A5
    sw = 10'h000;
    ticks(10);
    rd(32'hC0, "t2_sw0", 32'h0);
    sw = 10'h2A5;
    for (int k = 0; k <= 7; k++)
      rd(32'hC0, $sformatf("t2_sw_e%0d", k), (k >= 6) ? 32'h2A5 : 32'h0);

    // 3. bit0 bounce shorter than the window never changes stable
    sw = 10'h2A4;
    ticks(10);
    for (int c = 0; c < 20; c++) begin
      sw[0] = ((c / 2) % 2 == 0) ? 1'b1 : 1'b0;
      rd(32'hC0, $sformatf("t3_bounce_%0d", c), 32'h2A4);
    end
    sw[0] = 1'b0;
    ticks(6);
    rd(32'hC0, "t3_settled", 32'h2A4);

    // 4. key[2] press and release; event sticky until read
    key = 4'hF;
    ticks(10);
    chk("t4_rel_irq", {31'b0, key_irq}, 32'h0);
    key = 4'hB;
    ticks(10);
    key = 4'hF;
    ticks(8);
    chk("t4_irq_pend", {31'b0, key_irq}, 32'h1);
    rd(32'hC8, "t4_evt1", 32'h4);
    chk("t4_irq_fall", {31'b0, key_irq}, 32'h0);
    rd(32'hC8, "t4_evt2", 32'h0);

    // 5. clearing read on the same edge key[1] debounces pressed: set wins
    key = 4'hD;
    ticks(5);
    rd(32'hC8, "t5_same_edge", 32'h0);
    chk("t5_irq", {31'b0, key_irq}, 32'h1);
    rd(32'hC8, "t5_next", 32'h2);
    chk("t5_irq_clr", {31'b0, key_irq}, 32'h0);

    // 6. unmapped read leaves events alone; reset mid-debounce
    key = 4'hF;
    ticks(8);
    key = 4'hE;
    ticks(8);
    rd(32'hD0, "t6_unmapped", 32'h0);
    chk("t6_irq_kept", {31'b0, key_irq}, 32'h1);
    rd(32'hC8, "t6_evt", 32'h1);
    rd(32'hC4, "t6_keylvl", 32'h1);
    key = 4'h6;
    ticks(3);
    resetn = 1'b0;
    #1;
    chk("t6_rst_irq", {31'b0, key_irq}, 32'h0);
    chk("t6_rst_data", data_out, 32'h0);
    key = 4'hF;
    ticks(2);
    resetn = 1'b1;
    rd(32'hC0, "t6_sw_after_rst", 32'h0);
    ticks(10);
    chk("t6_no_evt_irq", {31'b0, key_irq}, 32'h0);
    rd(32'hC8, "t6_no_evt", 32'h0);
    rd(32'hC4, "t6_keys_rel", 32'h0);
    rd(32'hC0, "t6_sw_back", 32'h2A4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
